// File: rtl/decoration_executor.sv
// Opcode consumer for the haunted-prop controller: decodes 4-bit opcodes and
// drives power, lamp colour, timed sounds and timed movement/fog effects.
module decoration_executor #(
  parameter int SOUND_CYCLES  = 8,
  parameter int EFFECT_CYCLES = 6,
  parameter int WAVE_HALF     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [3:0] op_code,
  output logic       op_ready,
  output logic       power,
  output logic [1:0] color,
  output logic [1:0] sound,
  output logic       sound_active,
  output logic       arm,
  output logic       jaw,
  output logic       fog,
  output logic       illegal,
  output logic [7:0] op_count
);

  localparam int SW = $clog2(SOUND_CYCLES + 1);
  localparam int EW = $clog2(EFFECT_CYCLES);
  localparam int WW = $clog2(WAVE_HALF + 1);
  localparam logic [SW-1:0] SND_LOAD  = SW'(SOUND_CYCLES - 1);
  localparam logic [EW-1:0] EFF_LOAD  = EW'(EFFECT_CYCLES - 1);
  localparam logic [WW-1:0] WAVE_LOAD = WW'(WAVE_HALF - 1);

  localparam logic [3:0] OP_ON    = 4'b0000;
  localparam logic [3:0] OP_RESET = 4'b0001;
  localparam logic [3:0] OP_WAVE  = 4'b1100;
  localparam logic [3:0] OP_JAW   = 4'b1101;
  localparam logic [3:0] OP_FOG   = 4'b1110;

  localparam logic [1:0] K_WAVE = 2'b00;
  localparam logic [1:0] K_JAW  = 2'b01;

  typedef enum logic [1:0] {OFF, IDLE, EFFECT} state_t;
  state_t state, state_nxt;

  logic          accept, acc_off, acc_idle, eff_last, counted;
  logic          is_color, is_sound, is_move, legal;
  logic [EW-1:0] eff_cnt;
  logic [SW-1:0] snd_cnt;
  logic [WW-1:0] wave_cnt;
  logic [1:0]    eff_kind;

  always_comb begin
    is_color = 1'b0;
    is_sound = 1'b0;
    is_move  = 1'b0;
    unique case (op_code[3:2])
      2'b01:   is_color = (op_code[1:0] != 2'b11);
      2'b10:   is_sound = (op_code[1:0] != 2'b11);
      2'b11:   is_move  = (op_code[1:0] != 2'b11);
      default: ;
    endcase
    legal = is_color | is_sound | is_move | (op_code == OP_ON) | (op_code == OP_RESET);
  end

  // Upstream stalls only while a movement effect is running.
  assign op_ready = (state != EFFECT);
  assign accept   = op_valid & op_ready;
  assign acc_off  = accept && (state == OFF);
  assign acc_idle = accept && (state == IDLE);
  assign eff_last = (state == EFFECT) && (eff_cnt == '0);
  assign counted  = (acc_off && op_code == OP_ON) ||
                    (acc_idle && legal && op_code != OP_RESET);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= OFF;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      OFF:    if (acc_off && op_code == OP_ON) state_nxt = IDLE;
      IDLE: begin
        if (acc_idle && op_code == OP_RESET) state_nxt = OFF;
        else if (acc_idle && is_move)        state_nxt = EFFECT;
      end
      EFFECT: if (eff_last) state_nxt = IDLE;
      default: state_nxt = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      power    <= 1'b0;
      color    <= 2'b00;
      illegal  <= 1'b0;
      op_count <= 8'd0;
    end else begin
      illegal <= acc_idle && !legal;
      if (acc_off && op_code == OP_ON) power <= 1'b1;
      if (acc_idle && op_code == OP_RESET) begin
        power    <= 1'b0;
        color    <= 2'b00;
        op_count <= 8'd0;
      end else begin
        if (counted && op_count != 8'hFF) op_count <= op_count + 8'd1;
        if (acc_idle && is_color)         color    <= op_code[1:0] + 2'd1;
      end
    end
  end

  // A new sound takes priority over expiry on the same edge, restarting the timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sound        <= 2'b00;
      sound_active <= 1'b0;
      snd_cnt      <= '0;
    end else if (acc_idle && is_sound) begin
      sound        <= op_code[1:0] + 2'd1;
      sound_active <= 1'b1;
      snd_cnt      <= SND_LOAD;
    end else if (acc_idle && op_code == OP_RESET) begin
      sound        <= 2'b00;
      sound_active <= 1'b0;
      snd_cnt      <= '0;
    end else if (sound_active) begin
      if (snd_cnt == '0) begin
        sound        <= 2'b00;
        sound_active <= 1'b0;
      end else begin
        snd_cnt <= snd_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eff_cnt  <= '0;
      eff_kind <= 2'b00;
      wave_cnt <= '0;
      arm      <= 1'b0;
      jaw      <= 1'b0;
      fog      <= 1'b0;
    end else if (acc_idle && is_move) begin
      eff_cnt  <= EFF_LOAD;
      eff_kind <= op_code[1:0];
      wave_cnt <= WAVE_LOAD;
      arm      <= (op_code == OP_WAVE);
      jaw      <= (op_code == OP_JAW);
      fog      <= (op_code == OP_FOG);
    end else if (eff_last) begin
      arm <= 1'b0;
      jaw <= 1'b0;
      fog <= 1'b0;
    end else if (state == EFFECT) begin
      eff_cnt <= eff_cnt - 1'b1;
      if (eff_kind == K_WAVE) begin
        if (wave_cnt == '0) begin
          arm      <= ~arm;
          wave_cnt <= WAVE_LOAD;
        end else begin
          wave_cnt <= wave_cnt - 1'b1;
        end
      end
      if (eff_kind == K_JAW) jaw <= ~jaw;
    end
  end

endmodule

// File: tb/tb_decoration_executor.sv
// Randomized bench for decoration_executor: a timestamp-based model predicts
// every output each cycle; directed sequences pin key behaviours to literals.
module tb_decoration_executor;
  localparam int S  = 8;
  localparam int EC = 6;
  localparam int WH = 2;
  localparam int NEVER = -1000000;

  logic       clk = 1'b0, rst = 1'b0, op_valid = 1'b0;
  logic [3:0] op_code = 4'd0;
  logic       op_ready, power, sound_active, arm, jaw, fog, illegal;
  logic [1:0] color, sound;
  logic [7:0] op_count;

  always #5 clk = ~clk;

  decoration_executor #(.SOUND_CYCLES(S), .EFFECT_CYCLES(EC), .WAVE_HALF(WH)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .power(power), .color(color), .sound(sound),
    .sound_active(sound_active), .arm(arm), .jaw(jaw), .fog(fog),
    .illegal(illegal), .op_count(op_count)
  );

  int pass_cnt = 0, total_cnt = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: state as timestamps (edge index of acceptance) rather than counters.
  int n = 0;
  bit m_on = 1'b0;
  int m_color = 0, m_count = 0, snd_code = 0, eff_kind = 0;
  int snd_e = NEVER, eff_e = NEVER, ill_e = NEVER;

  task automatic mreset();
    m_on = 1'b0; m_color = 0; m_count = 0; snd_code = 0; eff_kind = 0;
    snd_e = NEVER; eff_e = NEVER; ill_e = NEVER;
  endtask

  task automatic bump();
    if (m_count < 255) m_count++;
  endtask

  task automatic step();
    bit acc;
    int op;
    acc = op_valid && ((n - eff_e) >= EC);
    n++;
    if (acc) begin
      op = int'(op_code);
      if (!m_on) begin
        if (op == 0) begin m_on = 1'b1; bump(); end
      end else if (op == 0) bump();
      else if (op == 1) begin
        m_on = 1'b0; m_color = 0; m_count = 0; snd_e = NEVER;
      end else if (op >= 4 && op <= 6) begin m_color = op - 3; bump(); end
      else if (op >= 8 && op <= 10) begin snd_code = op - 7; snd_e = n; bump(); end
      else if (op >= 12 && op <= 14) begin eff_kind = op - 12; eff_e = n; bump(); end
      else ill_e = n;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) mreset();
    else      step();
  end

  function automatic logic [18:0] exp_vec();
    int k, ks;
    bit busy, sa;
    k = n - eff_e;
    ks = n - snd_e;
    busy = (k < EC);
    sa = (ks < S);
    return {!busy, m_on, 2'(m_color), (sa ? 2'(snd_code) : 2'b00), sa,
            busy && eff_kind == 0 && ((k / WH) % 2 == 0),
            busy && eff_kind == 1 && (k % 2 == 0),
            busy && eff_kind == 2,
            ill_e == n, 8'(m_count)};
  endfunction

  task automatic idle(input int k);
    op_valid = 1'b0;
    repeat (k) begin
      op_code = 4'($urandom);
      @(posedge clk); #2;
    end
  endtask

  task automatic send(input logic [3:0] op);
    int w;
    logic rdy;
    w = 0;
    op_valid = 1'b1;
    op_code = op;
    do begin
      rdy = op_ready;
      @(posedge clk); #2;
      w++;
    end while (!rdy && w < 50);
    if (!rdy) chk("send_timeout", 0, 1);
    op_valid = 1'b0;
    op_code = 4'($urandom);
  endtask

  task automatic areset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] arm_pat, rdy_pat;
    logic [6:0] exp_arm, exp_rdy;
    int ne, r, op;

    fork
      forever begin
        @(negedge clk);
        if (check_en)
          chk("cycle_compare",
              int'({op_ready, power, color, sound, sound_active, arm, jaw, fog, illegal, op_count}),
              int'(exp_vec()));
      end
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk("reset_op_ready", int'(op_ready), 1);
    chk("reset_power", int'(power), 0);
    chk("reset_op_count", int'(op_count), 0);
    rst = 1'b1;
    check_en = 1'b1;

    // ON from reset
    send(4'b0000);
    chk("on_power", int'(power), 1);
    chk("on_count", int'(op_count), 1);
    chk("on_ready", int'(op_ready), 1);
    chk("on_color", int'(color), 0);
    chk("on_sound", int'(sound), 0);

    // Opcodes in OFF are discarded
    areset();
    send(4'b0100);
    send(4'b1010);
    chk("off_color", int'(color), 0);
    chk("off_sound", int'(sound), 0);
    chk("off_count", int'(op_count), 0);

    // Sound timing and restart
    send(4'b0000);
    send(4'b1000);
    idle(7);
    chk("scream_last", int'(sound_active), 1);
    chk("scream_code", int'(sound), 1);
    idle(1);
    chk("scream_end", int'(sound_active), 0);
    send(4'b0101);
    send(4'b1001);
    chk("purple", int'(color), 2);
    chk("cackle", int'(sound), 2);
    idle(4);
    chk("cackle_mid", int'(sound_active), 1);
    send(4'b1001);
    idle(7);
    chk("cackle_restart_last", int'(sound_active), 1);
    idle(1);
    chk("cackle_restart_end", int'(sound_active), 0);
    chk("cackle_restart_code", int'(sound), 0);

    // Wave pattern and ready stall
    send(4'b1100);
    for (int k = 0; k < 7; k++) begin
      arm_pat[k] = arm;
      rdy_pat[k] = op_ready;
      idle(1);
    end
    exp_arm = 7'b0110011;
    exp_rdy = 7'b1000000;
    chk("arm_pattern", int'(arm_pat), int'(exp_arm));
    chk("ready_pattern", int'(rdy_pat), int'(exp_rdy));
    send(4'b1100);
    ne = n;
    send(4'b0110);
    chk("orange_latency", n - ne, 7);
    chk("orange", int'(color), 3);

    // Async reset mid-fog
    areset();
    send(4'b0000);
    send(4'b1110);
    chk("fog_on", int'(fog), 1);
    idle(2);
    chk("fog_cycle3", int'(fog), 1);
    chk("fog_stall", int'(op_ready), 0);
    rst = 1'b0;
    #1;
    chk("areset_fog", int'(fog), 0);
    chk("areset_power", int'(power), 0);
    chk("areset_ready", int'(op_ready), 1);
    #1;
    rst = 1'b1;
    send(4'b0101);
    chk("areset_off_state", int'(color), 0);

    // Illegal opcode then RESET
    send(4'b0000);
    send(4'b0100);
    send(4'b1111);
    chk("illegal_pulse", int'(illegal), 1);
    chk("illegal_count", int'(op_count), 2);
    idle(1);
    chk("illegal_drop", int'(illegal), 0);
    send(4'b0001);
    chk("reset_op_power", int'(power), 0);
    chk("reset_op_count2", int'(op_count), 0);
    chk("reset_op_color", int'(color), 0);

    // Saturation
    send(4'b0000);
    for (int i = 0; i < 260; i++) send((i % 2 == 0) ? 4'b0100 : 4'b0101);
    chk("count_saturate", int'(op_count), 255);

    // Random traffic against the model
    areset();
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) areset();
      else begin
        op = int'($urandom_range(0, 15));
        if (op == 1 && $urandom_range(0, 2) != 0) op = 0;
        send(4'(op));
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 9)));
      end
    end

    idle(3);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
